// File: rtl/path_delay_meter.sv
// Launches an edge into a delay chain and counts clk cycles until the synchronized chain output
// follows it. Optional baseline-deviation alarm is built only with `define PATH_DELAY_ALARM_EN.
module path_delay_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 4095,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ALARM_TOL   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             launch_o,
  input  logic             path_i,
  output logic             busy,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_cycles,
  output logic             meas_timeout,
  output logic             meas_edge,
  input  logic [CNT_W-1:0] baseline,
  output logic             alarm
);

  localparam logic [CNT_W-1:0] TimeoutC    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SettleLastC = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSettle, StLaunch, StWait, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ref_q, ref_d;
  logic                   launch_q, launch_d;
  logic [CNT_W-1:0]       cycles_q, cycles_d;
  logic                   timeout_q, timeout_d;
  logic                   edge_q, edge_d;
  logic                   done_entry;
  logic                   path_s;

  assign path_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], path_i};
    ref_d      = ref_q;
    launch_d   = launch_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    edge_d     = edge_q;
    done_entry = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        // Latching ref at the end of settle absorbs any late chain activity.
        if (cnt_q == SettleLastC) begin
          ref_d   = path_s;
          cnt_d   = '0;
          state_d = StLaunch;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLaunch: begin
        launch_d = ~launch_q;
        edge_d   = ~launch_q;
        cnt_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (path_s != ref_q) begin
          cycles_d   = cnt_q;
          timeout_d  = 1'b0;
          state_d    = StDone;
          done_entry = 1'b1;
        end else if (cnt_q == TimeoutC) begin
          cycles_d   = TimeoutC;
          timeout_d  = 1'b1;
          state_d    = StDone;
          done_entry = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (meas_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sync_q    <= '0;
      ref_q     <= 1'b0;
      launch_q  <= 1'b0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      ref_q     <= ref_d;
      launch_q  <= launch_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
      edge_q    <= edge_d;
    end
  end

`ifdef PATH_DELAY_ALARM_EN
  logic             alarm_q, alarm_d;
  logic [CNT_W:0]   meas_ext, base_ext, diff;

  always_comb begin
    meas_ext = {1'b0, cycles_d};
    base_ext = {1'b0, baseline};
    diff     = (meas_ext >= base_ext) ? (meas_ext - base_ext) : (base_ext - meas_ext);
    alarm_d  = alarm_q;
    if (done_entry && ((diff > (CNT_W + 1)'(ALARM_TOL)) || timeout_d)) alarm_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  logic unused_sig;
  assign unused_sig = ^{baseline, done_entry};
  assign alarm      = 1'b0;
`endif

  assign launch_o     = launch_q;
  assign busy         = (state_q != StIdle);
  assign meas_valid   = (state_q == StDone);
  assign meas_cycles  = cycles_q;
  assign meas_timeout = timeout_q;
  assign meas_edge    = edge_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// Bench for path_delay_meter: delayed-chain model, scenario tasks and a randomized sweep
// checked against an arithmetic model of the expected cycle count.
module tb_path_delay_meter;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;
  localparam int SYNC    = 2;
  localparam int PERIOD  = 10;
  localparam int TOL     = 2;
`ifdef PATH_DELAY_ALARM_EN
  localparam bit AlarmOn = 1'b1;
`else
  localparam bit AlarmOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, meas_ready = 1'b1;
  logic launch_o, path_i, busy, meas_valid, meas_timeout, meas_edge, alarm;
  logic [CNT_W-1:0] meas_cycles;
  logic [CNT_W-1:0] baseline = 16'd2;

  int n_cmp = 0;
  int n_bad = 0;
  int path_dly = 0;
  bit tie_low = 1'b0;
  logic path_del = 1'b0;
  bit exp_lvl = 1'b0;
  bit exp_alarm = 1'b0;

  path_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SETTLE_CYC(8), .SYNC_STAGES(SYNC),
                     .ALARM_TOL(TOL)) dut (
    .clk(clk), .rst(rst), .start(start), .launch_o(launch_o), .path_i(path_i), .busy(busy),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_cycles(meas_cycles),
    .meas_timeout(meas_timeout), .meas_edge(meas_edge), .baseline(baseline), .alarm(alarm)
  );

  always #(PERIOD/2) clk = ~clk;

  // Chain model: transport delay of path_dly time units, or wire/ground.
  always @(launch_o) path_del <= #(path_dly) launch_o;
  assign path_i = tie_low ? 1'b0 : ((path_dly == 0) ? launch_o : path_del);

  // Expected count: edges until the first sync flop captures, plus the remaining sync stages.
  function automatic int model_count(int d);
    int c = d / PERIOD + SYNC;
    return (tie_low || c > TIMEOUT) ? TIMEOUT : c;
  endfunction

  function automatic bit model_to(int d);
    return tie_low || (d / PERIOD + SYNC > TIMEOUT);
  endfunction

  function automatic bit model_dev(int c, int b, bit to);
    int df = (c > b) ? c - b : b - c;
    return AlarmOn && (to || df > TOL);
  endfunction

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_lvl = 1'b0;
    exp_alarm = 1'b0;
  endtask

  task automatic run_meas(output int cyc, output bit to, output bit edg, output int pulses,
                          output bit got);
    got = 1'b0; pulses = 0; cyc = 0; to = 1'b0; edg = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        got = 1'b1; cyc = int'(meas_cycles); to = meas_timeout; edg = meas_edge; pulses = 1;
      end
    end
    if (got) for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (meas_valid) pulses++;
    end
    exp_lvl = ~exp_lvl;
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({launch_o, busy, meas_valid, meas_cycles, meas_timeout, meas_edge, alarm} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got l=%b b=%b v=%b c=%0d t=%b e=%b a=%b, want all 0",
               launch_o, busy, meas_valid, meas_cycles, meas_timeout, meas_edge, alarm);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_zero_delay();
    int cyc, pulses; bit to, edg, got;
    path_dly = 0;
    run_meas(cyc, to, edg, pulses, got);
    exp_alarm |= model_dev(2, int'(baseline), 1'b0);
    n_cmp++;
    if (!got || cyc != 2 || to !== 1'b0 || edg !== 1'b1 || launch_o !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_delay: got=%b cyc=%0d to=%b edge=%b launch=%b, want 1 2 0 1 1",
               got, cyc, to, edg, launch_o);
    end
    n_cmp++;
    if (pulses != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_delay_pulse: pulses=%0d busy=%b, want 1 0", pulses, busy);
    end
    n_cmp++;
    if (alarm !== exp_alarm) begin
      n_bad++;
      $display("FAIL zero_delay_alarm: got %b want %b", alarm, exp_alarm);
    end
  endtask

  task automatic test_delay_25();
    int cyc, pulses; bit to, edg, got;
    do_reset();
    path_dly = 25;
    for (int k = 0; k < 2; k++) begin
      run_meas(cyc, to, edg, pulses, got);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (!got || cyc != 4 || to !== 1'b0 || edg !== exp_lvl || launch_o !== exp_lvl) begin
        n_bad++;
        $display("FAIL delay_25[%0d]: got=%b cyc=%0d to=%b edge=%b launch=%b, want 1 4 0 %b %b",
                 k, got, cyc, to, edg, launch_o, exp_lvl, exp_lvl);
      end
    end
  endtask

  task automatic test_alarm();
    int cyc, pulses; bit to, edg, got;
    int dl [2] = '{25, 65};
    do_reset();
    baseline = 16'd4;
    for (int k = 0; k < 2; k++) begin
      path_dly = dl[k];
      run_meas(cyc, to, edg, pulses, got);
      exp_alarm |= model_dev(model_count(dl[k]), 4, 1'b0);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (!got || cyc != model_count(dl[k]) || alarm !== exp_alarm) begin
        n_bad++;
        $display("FAIL alarm[%0d]: got=%b cyc=%0d alarm=%b, want 1 %0d %b",
                 k, got, cyc, alarm, model_count(dl[k]), exp_alarm);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc, pulses; bit to, edg, got;
    tie_low = 1'b1;
    run_meas(cyc, to, edg, pulses, got);
    exp_alarm |= model_dev(TIMEOUT, int'(baseline), 1'b1);
    n_cmp++;
    if (!got || cyc != TIMEOUT || to !== 1'b1 || alarm !== exp_alarm) begin
      n_bad++;
      $display("FAIL timeout: got=%b cyc=%0d to=%b alarm=%b, want 1 %0d 1 %b",
               got, cyc, to, alarm, TIMEOUT, exp_alarm);
    end
    tie_low = 1'b0;
    path_dly = 0;
    repeat (5) @(negedge clk);
    baseline = 16'd2;
    run_meas(cyc, to, edg, pulses, got);
    n_cmp++;
    if (!got || cyc != 2 || to !== 1'b0 || alarm !== exp_alarm) begin
      n_bad++;
      $display("FAIL timeout_sticky: got=%b cyc=%0d to=%b alarm=%b, want 1 2 0 %b",
               got, cyc, to, alarm, exp_alarm);
    end
  endtask

  task automatic test_ready_hold();
    logic [CNT_W+1:0] snap;
    bit got = 1'b0;
    path_dly = 0;
    meas_ready = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = meas_valid;
    end
    exp_lvl = ~exp_lvl;
    snap = {meas_cycles, meas_timeout, meas_edge};
    n_cmp++;
    if (!got || snap !== {16'd2, 1'b0, exp_lvl}) begin
      n_bad++;
      $display("FAIL hold_entry: got=%b outs=%h, want 1 %h", got, snap, {16'd2, 1'b0, exp_lvl});
    end
    for (int i = 0; i < 7; i++) begin
      start = (i == 3);
      @(negedge clk);
      n_cmp++;
      if (meas_valid !== 1'b1 || busy !== 1'b1 || {meas_cycles, meas_timeout, meas_edge} !== snap)
      begin
        n_bad++;
        $display("FAIL hold[%0d]: valid=%b busy=%b outs=%h, want 1 1 %h", i, meas_valid, busy,
                 {meas_cycles, meas_timeout, meas_edge}, snap);
      end
    end
    start = 1'b0;
    meas_ready = 1'b1;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (meas_valid !== 1'b0 || busy !== 1'b0 || {meas_cycles, meas_timeout, meas_edge} !== snap)
      begin
        n_bad++;
        $display("FAIL hold_release: valid=%b busy=%b outs=%h, want 0 0 %h", meas_valid, busy,
                 {meas_cycles, meas_timeout, meas_edge}, snap);
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc, pulses; bit to, edg, got;
    path_dly = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (launch_o !== ~exp_lvl || busy !== 1'b1 || meas_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_wait: launch=%b busy=%b valid=%b, want %b 1 0", launch_o, busy,
               meas_valid, ~exp_lvl);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({launch_o, busy, meas_valid, alarm} !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_reset: launch=%b busy=%b valid=%b alarm=%b, want 0 0 0 0", launch_o,
               busy, meas_valid, alarm);
    end
    rst = 1'b0;
    exp_lvl = 1'b0;
    exp_alarm = 1'b0;
    run_meas(cyc, to, edg, pulses, got);
    n_cmp++;
    if (!got || cyc != 2 || to !== 1'b0 || edg !== 1'b1 || pulses != 1) begin
      n_bad++;
      $display("FAIL after_reset: got=%b cyc=%0d to=%b edge=%b pulses=%0d, want 1 2 0 1 1",
               got, cyc, to, edg, pulses);
    end
  endtask

  task automatic test_random();
    int cyc, pulses, d, ec; bit to, edg, got, et;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      d = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 24) * PERIOD + $urandom_range(1, 9);
      baseline = CNT_W'($urandom_range(0, 24));
      path_dly = d;
      ec = model_count(d);
      et = model_to(d);
      run_meas(cyc, to, edg, pulses, got);
      exp_alarm |= model_dev(ec, int'(baseline), et);
      n_cmp++;
      if (!got || cyc != ec || to !== et || edg !== exp_lvl || pulses != 1 || alarm !== exp_alarm)
      begin
        n_bad++;
        $display("FAIL random[%0d] d=%0d: got=%b cyc=%0d to=%b edge=%b pulses=%0d alarm=%b, want 1 %0d %b %b 1 %b",
                 k, d, got, cyc, to, edg, pulses, alarm, ec, et, exp_lvl, exp_alarm);
      end
      repeat (30) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_zero_delay();
    test_delay_25();
    test_alarm();
    test_timeout();
    test_ready_hold();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
